// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch, load and store with in-order tagged reads.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
    parameter int READ_LAT     = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        f_req,
    input  logic [14:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [15:0] f_rdata,
    input  logic        l_req,
    input  logic [14:0] l_addr,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [15:0] l_rdata,
    input  logic        s_req,
    input  logic [14:0] s_addr,
    input  logic [15:0] s_data,
    output logic        s_gnt,
    output logic        m_ren,
    output logic [14:0] m_raddr,
    input  logic [15:0] m_rdata,
    output logic        m_wen,
    output logic [14:0] m_waddr,
    output logic [15:0] m_wdata,
    output logic [15:0] stat_f_wait,
    output logic [15:0] stat_boost
);

    typedef enum logic {ST_NORMAL = 1'b0, ST_BOOST = 1'b1} state_t;

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    state_t            r_state;
    logic [3:0]        r_starve;
    logic [READ_LAT:0] r_tag_vld;
    logic [READ_LAT:0] r_tag_ld;
    logic              r_m_ren;
    logic              r_m_wen;
    logic [14:0]       r_m_raddr;
    logic [14:0]       r_m_waddr;
    logic [15:0]       r_m_wdata;
    logic              r_f_rvalid;
    logic              r_l_rvalid;
    logic [15:0]       r_f_rdata;
    logic [15:0]       r_l_rdata;

    logic              w_f_gnt;
    logic              w_l_gnt;
    logic              w_s_gnt;
    logic [3:0]        w_starve_nxt;
    logic              w_enter_boost;

    always_comb begin
        w_f_gnt = 1'b0;
        w_l_gnt = 1'b0;
        w_s_gnt = 1'b0;
        if (rst_n) begin
            if (r_state == ST_BOOST && f_req) w_f_gnt = 1'b1;
            else if (s_req)                   w_s_gnt = 1'b1;
            else if (l_req)                   w_l_gnt = 1'b1;
            else if (f_req)                   w_f_gnt = 1'b1;
        end
    end

    always_comb begin
        w_starve_nxt = 4'd0;
        if (f_req && !w_f_gnt)
            w_starve_nxt = (r_starve == 4'hf) ? 4'hf : r_starve + 4'd1;
    end

    assign w_enter_boost = (r_state == ST_NORMAL) && (w_starve_nxt == LP_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_NORMAL;
            r_starve   <= 4'd0;
            r_tag_vld  <= '0;
            r_tag_ld   <= '0;
            r_m_ren    <= 1'b0;
            r_m_wen    <= 1'b0;
            r_m_raddr  <= 15'd0;
            r_m_waddr  <= 15'd0;
            r_m_wdata  <= 16'd0;
            r_f_rvalid <= 1'b0;
            r_l_rvalid <= 1'b0;
            r_f_rdata  <= 16'd0;
            r_l_rdata  <= 16'd0;
        end else begin
            r_starve <= w_starve_nxt;
            case (r_state)
                ST_NORMAL: if (w_enter_boost) r_state <= ST_BOOST;
                ST_BOOST:  if (w_f_gnt || !f_req) r_state <= ST_NORMAL;
                default:   r_state <= ST_NORMAL;
            endcase

            r_m_ren <= w_f_gnt | w_l_gnt;
            r_m_wen <= w_s_gnt;
            if (w_l_gnt)      r_m_raddr <= l_addr;
            else if (w_f_gnt) r_m_raddr <= f_addr;
            if (w_s_gnt) begin
                r_m_waddr <= s_addr;
                r_m_wdata <= s_data;
            end

            // A flush kills fetch tags still short of the data stage; the one being consumed survives.
            r_tag_vld[0] <= w_l_gnt | (w_f_gnt & ~flush);
            r_tag_ld[0]  <= w_l_gnt;
            for (int i = 1; i <= READ_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1] & (r_tag_ld[i-1] | ~flush);
                r_tag_ld[i]  <= r_tag_ld[i-1];
            end

            r_f_rvalid <= r_tag_vld[READ_LAT] & ~r_tag_ld[READ_LAT];
            r_l_rvalid <= r_tag_vld[READ_LAT] &  r_tag_ld[READ_LAT];
            if (r_tag_vld[READ_LAT] && !r_tag_ld[READ_LAT]) r_f_rdata <= m_rdata;
            if (r_tag_vld[READ_LAT] &&  r_tag_ld[READ_LAT]) r_l_rdata <= m_rdata;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_stat_f_wait;
    logic [15:0] r_stat_boost;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_f_wait <= 16'd0;
            r_stat_boost  <= 16'd0;
        end else begin
            if (f_req && !w_f_gnt && r_stat_f_wait != 16'hffff)
                r_stat_f_wait <= r_stat_f_wait + 16'd1;
            if (w_enter_boost && r_stat_boost != 16'hffff)
                r_stat_boost <= r_stat_boost + 16'd1;
        end
    end

    assign stat_f_wait = r_stat_f_wait;
    assign stat_boost  = r_stat_boost;
`else
    assign stat_f_wait = 16'h0;
    assign stat_boost  = 16'h0;
`endif

    assign f_gnt    = w_f_gnt;
    assign l_gnt    = w_l_gnt;
    assign s_gnt    = w_s_gnt;
    assign m_ren    = r_m_ren;
    assign m_raddr  = r_m_raddr;
    assign m_wen    = r_m_wen;
    assign m_waddr  = r_m_waddr;
    assign m_wdata  = r_m_wdata;
    assign f_rvalid = r_f_rvalid;
    assign f_rdata  = r_f_rdata;
    assign l_rvalid = r_l_rvalid;
    assign l_rdata  = r_l_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic against a cycle-indexed reference.
// Statistics expectations follow MEM_ARB_STATS_EN.
module tb_mem_port_arbiter;
    localparam int RL = 1;
    localparam int SL = 4;
    localparam int NC = 4096;

    logic        clk = 1'b0;
    logic        rst_n, flush, f_req, l_req, s_req;
    logic [14:0] f_addr, l_addr, s_addr;
    logic [15:0] s_data;
    logic        f_gnt, f_rvalid, l_gnt, l_rvalid, s_gnt, m_ren, m_wen;
    logic [15:0] f_rdata, l_rdata, m_rdata, m_wdata, stat_f_wait, stat_boost;
    logic [14:0] m_raddr, m_waddr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.READ_LAT(RL), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_addr(l_addr), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .s_req(s_req), .s_addr(s_addr), .s_data(s_data), .s_gnt(s_gnt),
        .m_ren(m_ren), .m_raddr(m_raddr), .m_rdata(m_rdata),
        .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .stat_f_wait(stat_f_wait), .stat_boost(stat_boost)
    );

    function automatic logic [15:0] dflt(input logic [14:0] a);
        return (a == 15'h0010) ? 16'hbeef : (({1'b0, a} * 16'h9e37) ^ 16'h5a5a);
    endfunction

    // Memory behind the DUT: untouched words read their default pattern.
    logic [15:0] mem_w [int];
    logic [15:0] rd_pipe [0:RL-1];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_w.exists(int'(m_raddr)) ? mem_w[int'(m_raddr)] : dflt(m_raddr);
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
        if (m_wen) mem_w[int'(m_waddr)] = m_wdata;
    end
    assign m_rdata = rd_pipe[RL-1];

    // Reference: expected registered outputs per cycle, and the memory image as the core sees it.
    logic [15:0] ref_w [int];
    logic        e_ren [0:NC-1];
    logic        e_wen [0:NC-1];
    logic        e_fv  [0:NC-1];
    logic        e_lv  [0:NC-1];
    logic [14:0] e_raddr [0:NC-1];
    logic [14:0] e_waddr [0:NC-1];
    logic [15:0] e_wdata [0:NC-1];
    logic [15:0] e_fd [0:NC-1];
    logic [15:0] e_ld [0:NC-1];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int streak = 0;
    int m_fwait = 0;
    int m_boost = 0;
    int f_rv_cnt = 0;
    int l_rv_cnt = 0;
    logic [2:0] last_gnt;

    function automatic logic [15:0] ref_rd(input logic [14:0] a);
        return ref_w.exists(int'(a)) ? ref_w[int'(a)] : dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_m_ren"},    32'(m_ren),    32'd0);
        chk({tag, "_m_wen"},    32'(m_wen),    32'd0);
        chk({tag, "_m_raddr"},  32'(m_raddr),  32'd0);
        chk({tag, "_m_waddr"},  32'(m_waddr),  32'd0);
        chk({tag, "_m_wdata"},  32'(m_wdata),  32'd0);
        chk({tag, "_f_rvalid"}, 32'(f_rvalid), 32'd0);
        chk({tag, "_f_rdata"},  32'(f_rdata),  32'd0);
        chk({tag, "_l_rvalid"}, 32'(l_rvalid), 32'd0);
        chk({tag, "_l_rdata"},  32'(l_rdata),  32'd0);
        chk({tag, "_stat_fw"},  32'(stat_f_wait), 32'd0);
        chk({tag, "_stat_bo"},  32'(stat_boost),  32'd0);
    endtask

    // One clock cycle: check at negedge, advance the reference, step past the posedge.
    task automatic tick();
        logic [2:0] exp_g;
        int due;
        @(negedge clk);
        exp_g = 3'b000;
        if (rst_n) begin
            // A fetch denied STARVE_LIMIT cycles in a row outranks everything.
            if (streak == SL && f_req) exp_g = 3'b001;
            else if (s_req)            exp_g = 3'b100;
            else if (l_req)            exp_g = 3'b010;
            else if (f_req)            exp_g = 3'b001;
        end
        last_gnt = {s_gnt, l_gnt, f_gnt};
        if (chk_en) begin
            chk("gnt", 32'(last_gnt), 32'(exp_g));
            chk("m_ren", 32'(m_ren), 32'(e_ren[cyc]));
            if (e_ren[cyc]) chk("m_raddr", 32'(m_raddr), 32'(e_raddr[cyc]));
            chk("m_wen", 32'(m_wen), 32'(e_wen[cyc]));
            if (e_wen[cyc]) begin
                chk("m_waddr", 32'(m_waddr), 32'(e_waddr[cyc]));
                chk("m_wdata", 32'(m_wdata), 32'(e_wdata[cyc]));
            end
            chk("f_rvalid", 32'(f_rvalid), 32'(e_fv[cyc]));
            if (e_fv[cyc]) chk("f_rdata", 32'(f_rdata), 32'(e_fd[cyc]));
            chk("l_rvalid", 32'(l_rvalid), 32'(e_lv[cyc]));
            if (e_lv[cyc]) chk("l_rdata", 32'(l_rdata), 32'(e_ld[cyc]));
            chk("ren_wen_excl", 32'(m_ren & m_wen), 32'd0);
`ifdef MEM_ARB_STATS_EN
            chk("stat_f_wait", 32'(stat_f_wait), 32'(m_fwait));
            chk("stat_boost",  32'(stat_boost),  32'(m_boost));
`else
            chk("stat_f_wait", 32'(stat_f_wait), 32'd0);
            chk("stat_boost",  32'(stat_boost),  32'd0);
`endif
        end
        f_rv_cnt += int'(f_rvalid);
        l_rv_cnt += int'(l_rvalid);

        due = cyc + 2 + RL;
        if (rst_n) begin
            if (exp_g[2]) begin
                ref_w[int'(s_addr)] = s_data;
                e_wen[cyc+1] = 1'b1; e_waddr[cyc+1] = s_addr; e_wdata[cyc+1] = s_data;
            end
            if (exp_g[1]) begin
                e_ren[cyc+1] = 1'b1; e_raddr[cyc+1] = l_addr;
                e_lv[due] = 1'b1; e_ld[due] = ref_rd(l_addr);
            end
            if (exp_g[0]) begin
                e_ren[cyc+1] = 1'b1; e_raddr[cyc+1] = f_addr;
                if (!flush) begin e_fv[due] = 1'b1; e_fd[due] = ref_rd(f_addr); end
            end
            if (flush) for (int d = cyc + 2; d <= cyc + 1 + RL; d++) e_fv[d] = 1'b0;
            if (f_req && !exp_g[0]) begin
                if (m_fwait < 65535) m_fwait++;
                if (streak < 15) streak++;
                if (streak == SL && m_boost < 65535) m_boost++;
            end else begin
                streak = 0;
            end
        end else begin
            for (int d = cyc + 1; d <= cyc + 8; d++) begin
                e_ren[d] = 1'b0; e_wen[d] = 1'b0; e_fv[d] = 1'b0; e_lv[d] = 1'b0;
            end
            streak = 0; m_fwait = 0; m_boost = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        f_req = 1'b0; l_req = 1'b0; s_req = 1'b0; flush = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            e_ren[i] = 1'b0; e_wen[i] = 1'b0; e_fv[i] = 1'b0; e_lv[i] = 1'b0;
            e_raddr[i] = '0; e_waddr[i] = '0; e_wdata[i] = '0; e_fd[i] = '0; e_ld[i] = '0;
        end
        rst_n = 1'b0; flush = 1'b0;
        f_req = 1'b0; l_req = 1'b0; s_req = 1'b0;
        f_addr = '0; l_addr = '0; s_addr = '0; s_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        check_zero("reset");
        chk_en = 1'b1;

        // Lone fetch: grant now, strobe next cycle, data three cycles after grant.
        f_req = 1'b1; f_addr = 15'h0010;
        tick();
        chk("s1_fgnt", 32'(last_gnt), 32'b001);
        chk("s1_mren", 32'(m_ren), 32'd1);
        chk("s1_raddr", 32'(m_raddr), 32'h0010);
        f_req = 1'b0;
        tick(); tick();
        chk("s1_frvalid", 32'(f_rvalid), 32'd1);
        chk("s1_frdata", 32'(f_rdata), 32'hbeef);
        tick();
        chk("s1_frvalid_off", 32'(f_rvalid), 32'd0);

        // Store and load to one address in the same cycle.
        s_req = 1'b1; s_addr = 15'h0020; s_data = 16'h1234;
        l_req = 1'b1; l_addr = 15'h0020;
        tick();
        chk("s2_sgnt", 32'(last_gnt), 32'b100);
        chk("s2_mwen", 32'(m_wen), 32'd1);
        chk("s2_waddr", 32'(m_waddr), 32'h0020);
        chk("s2_wdata", 32'(m_wdata), 32'h1234);
        s_req = 1'b0;
        tick();
        chk("s2_lgnt", 32'(last_gnt), 32'b010);
        l_req = 1'b0;
        tick(); tick();
        chk("s2_lrvalid", 32'(l_rvalid), 32'd1);
        chk("s2_lrdata", 32'(l_rdata), 32'h1234);
        idle(3);

        // Starvation: store hogs the port, fetch wins on its fifth cycle.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_req = 1'b1; s_addr = 15'h0050 + 15'(i); s_data = 16'h7000 + 16'(i);
            f_req = (i < 5); f_addr = 15'h0060;
            tick();
            chk("s3_gnt", 32'(last_gnt), (i == 4) ? 32'b001 : 32'b100);
        end
`ifdef MEM_ARB_STATS_EN
        chk("s3_stat_f_wait", 32'(stat_f_wait), 32'd4);
        chk("s3_stat_boost", 32'(stat_boost), 32'd1);
`else
        chk("s3_stat_f_wait", 32'(stat_f_wait), 32'd0);
        chk("s3_stat_boost", 32'(stat_boost), 32'd0);
`endif
        idle(6);

        // Three back-to-back fetches, flush with the third, then a load.
        f_rv_cnt = 0; l_rv_cnt = 0;
        f_req = 1'b1; f_addr = 15'h0031; tick();
        f_addr = 15'h0032; tick();
        f_addr = 15'h0033; flush = 1'b1; tick();
        f_req = 1'b0; flush = 1'b0; l_req = 1'b1; l_addr = 15'h0044; tick();
        chk("s4_lgnt", 32'(last_gnt), 32'b010);
        idle(6);
        chk("s4_f_rv_cnt", 32'(f_rv_cnt), 32'd1);
        chk("s4_l_rv_cnt", 32'(l_rv_cnt), 32'd1);

        // Reset with a fetch and a load outstanding; requests held during reset get no grant.
        f_rv_cnt = 0; l_rv_cnt = 0;
        f_req = 1'b1; f_addr = 15'h0010; tick();
        f_req = 1'b0; l_req = 1'b1; l_addr = 15'h0020; tick();
        l_req = 1'b0; f_req = 1'b1; s_req = 1'b1; rst_n = 1'b0; tick();
        chk("s5_gnt_in_reset", 32'(last_gnt), 32'b000);
        rst_n = 1'b1;
        check_zero("s5");
        idle(5);
        chk("s5_f_rv_cnt", 32'(f_rv_cnt), 32'd0);
        chk("s5_l_rv_cnt", 32'(l_rv_cnt), 32'd0);
        f_req = 1'b1; f_addr = 15'h0010; tick();
        chk("s5_cold_fgnt", 32'(last_gnt), 32'b001);
        f_req = 1'b0; tick(); tick();
        chk("s5_cold_frvalid", 32'(f_rvalid), 32'd1);
        chk("s5_cold_frdata", 32'(f_rdata), 32'hbeef);
        idle(4);

        // Random traffic over a small address window so hazards are frequent.
        for (int i = 0; i < 1500; i++) begin
            rst_n  = ($urandom_range(0, 99) != 0);
            flush  = ($urandom_range(0, 9) == 0);
            f_req  = ($urandom_range(0, 99) < 70);
            l_req  = ($urandom_range(0, 99) < 40);
            s_req  = ($urandom_range(0, 99) < 35);
            f_addr = 15'($urandom_range(0, 15));
            l_addr = 15'($urandom_range(0, 15));
            s_addr = 15'($urandom_range(0, 15));
            s_data = 16'($urandom);
            tick();
        end
        rst_n = 1'b1;
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
